ddr3_ui_arbiter: RTL and testbench

Arbitrates the single DDR3 controller user interface (UI) command port between two clients:
- **Scanout reader:** the real-time framebuffer read path. It issues read commands.
- **Renderer pixel writer:** issues write commands together with their write data.

Reads have priority. A write quota bounds how long a write grant may hold off scanout. Read data (`rd_data_valid`/`rd_data`) bypasses this block and goes straight to the scanout FIFO, so read return needs no tagging.

---
 rtl/ddr3_ui_arbiter.sv | 134 +++++++++++++
 tb/tb_ddr3_ui_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ui_arbiter.sv
//------------------------------------------------------------------------------
// ddr3_ui_arbiter: grants the DDR3 UI command port to scanout reads (priority)
// or renderer writes, with a per-grant write quota. Option: DDR3_ARB_RD_URGENT_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_ui_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int WDF_WIDTH  = 128,
  parameter int WR_QUOTA   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   calib_done,
`ifdef DDR3_ARB_RD_URGENT_EN
  input  logic                   rd_urgent,
`endif
  input  logic                   rd_app_en,
  input  logic [ADDR_WIDTH-1:0]  rd_app_addr,
  output logic                   rd_app_rdy,
  input  logic                   wr_app_en,
  input  logic [ADDR_WIDTH-1:0]  wr_app_addr,
  input  logic [WDF_WIDTH-1:0]   wr_app_data,
  input  logic [WDF_WIDTH/8-1:0] wr_app_mask,
  output logic                   wr_app_rdy,
  output logic                   ddr3_app_en,
  output logic [2:0]             ddr3_app_cmd,
  output logic [ADDR_WIDTH-1:0]  ddr3_app_addr,
  input  logic                   ddr3_app_rdy,
  output logic                   ddr3_app_wdf_wren,
  output logic                   ddr3_app_wdf_end,
  output logic [WDF_WIDTH-1:0]   ddr3_app_wdf_data,
  output logic [WDF_WIDTH/8-1:0] ddr3_app_wdf_mask,
  input  logic                   ddr3_app_wdf_rdy,
  output logic                   arb_busy
);

  localparam logic [7:0] QUOTA   = 8'(WR_QUOTA);
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_WR  = 3'b000;

  typedef enum logic [1:0] {
    ST_CALIB = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] wr_cnt;
  logic [7:0] wr_cnt_inc;
  logic       urgent;
  logic       rd_fire;
  logic       wr_fire;

`ifdef DDR3_ARB_RD_URGENT_EN
  assign urgent = rd_urgent;
`else
  assign urgent = 1'b0;
`endif

  assign rd_fire    = (state == ST_READ) && rd_app_en && ddr3_app_rdy;
  assign wr_fire    = (state == ST_WRITE) && wr_app_en && ddr3_app_rdy && ddr3_app_wdf_rdy;
  // Count including this cycle's fire, so the quota hand-over happens on the last write.
  assign wr_cnt_inc = (wr_fire && (wr_cnt != QUOTA)) ? wr_cnt + 8'd1 : wr_cnt;

  always_ff @(posedge clk) begin
    if (rst || !calib_done) begin
      state  <= ST_CALIB;
      wr_cnt <= 8'd0;
    end else begin
      case (state)
        ST_CALIB: state <= ST_IDLE;
        ST_IDLE: begin
          if (rd_app_en) begin
            state <= ST_READ;
          end else if (wr_app_en) begin
            state  <= ST_WRITE;
            wr_cnt <= 8'd0;
          end
        end
        ST_READ: begin
          // An urgent scanout keeps the grant even between its read requests.
          if (!rd_app_en && !urgent) begin
            if (wr_app_en) begin
              state  <= ST_WRITE;
              wr_cnt <= 8'd0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          wr_cnt <= wr_cnt_inc;
          if (!wr_app_en) begin
            state <= rd_app_en ? ST_READ : ST_IDLE;
          end else if (rd_app_en && ((wr_cnt_inc == QUOTA) || urgent)) begin
            state <= ST_READ;
          end
        end
        default: state <= ST_CALIB;
      endcase
    end
  end

  always_comb begin
    ddr3_app_en       = 1'b0;
    ddr3_app_cmd      = CMD_RD;
    ddr3_app_addr     = rd_app_addr;
    ddr3_app_wdf_data = '0;
    ddr3_app_wdf_mask = '0;
    case (state)
      ST_READ:  ddr3_app_en = rd_app_en;
      ST_WRITE: begin
        ddr3_app_en       = wr_app_en && ddr3_app_wdf_rdy;
        ddr3_app_cmd      = CMD_WR;
        ddr3_app_addr     = wr_app_addr;
        ddr3_app_wdf_data = wr_app_data;
        ddr3_app_wdf_mask = wr_app_mask;
      end
      default: ;
    endcase
  end

  assign ddr3_app_wdf_wren = wr_fire;
  assign ddr3_app_wdf_end  = wr_fire;
  assign rd_app_rdy        = rd_fire;
  assign wr_app_rdy        = wr_fire;
  assign arb_busy          = (state == ST_READ) || (state == ST_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_ddr3_ui_arbiter.sv
// Randomized scoreboard bench for ddr3_ui_arbiter (WR_QUOTA = 4).
`default_nettype none

module tb_ddr3_ui_arbiter;
  localparam int AW   = 27;
  localparam int DW   = 128;
  localparam int MW   = DW / 8;
  localparam int Q    = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          calib_done = 1'b0;
  logic          rd_app_en = 1'b0;
  logic [AW-1:0] rd_app_addr = '0;
  logic          rd_app_rdy;
  logic          wr_app_en = 1'b0;
  logic [AW-1:0] wr_app_addr = '0;
  logic [DW-1:0] wr_app_data = '0;
  logic [MW-1:0] wr_app_mask = '0;
  logic          wr_app_rdy;
  logic          ddr3_app_en;
  logic [2:0]    ddr3_app_cmd;
  logic [AW-1:0] ddr3_app_addr;
  logic          ddr3_app_rdy = 1'b0;
  logic          ddr3_app_wdf_wren;
  logic          ddr3_app_wdf_end;
  logic [DW-1:0] ddr3_app_wdf_data;
  logic [MW-1:0] ddr3_app_wdf_mask;
  logic          ddr3_app_wdf_rdy = 1'b0;
  logic          arb_busy;
`ifdef DDR3_ARB_RD_URGENT_EN
  logic          rd_urgent = 1'b0;
`endif

  always #5 clk = ~clk;

  ddr3_ui_arbiter #(.ADDR_WIDTH(AW), .WDF_WIDTH(DW), .WR_QUOTA(Q)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
`ifdef DDR3_ARB_RD_URGENT_EN
    .rd_urgent(rd_urgent),
`endif
    .rd_app_en(rd_app_en), .rd_app_addr(rd_app_addr), .rd_app_rdy(rd_app_rdy),
    .wr_app_en(wr_app_en), .wr_app_addr(wr_app_addr), .wr_app_data(wr_app_data),
    .wr_app_mask(wr_app_mask), .wr_app_rdy(wr_app_rdy),
    .ddr3_app_en(ddr3_app_en), .ddr3_app_cmd(ddr3_app_cmd), .ddr3_app_addr(ddr3_app_addr),
    .ddr3_app_rdy(ddr3_app_rdy), .ddr3_app_wdf_wren(ddr3_app_wdf_wren),
    .ddr3_app_wdf_end(ddr3_app_wdf_end), .ddr3_app_wdf_data(ddr3_app_wdf_data),
    .ddr3_app_wdf_mask(ddr3_app_wdf_mask), .ddr3_app_wdf_rdy(ddr3_app_wdf_rdy),
    .arb_busy(arb_busy)
  );

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } cmd_t;

  cmd_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   running = 1'b0;
  bit   reset_chk = 1'b0;

  // Reference model: grant 0=calib 1=idle 2=read 3=write, plus writes taken this grant.
  int       g = 0;
  int       cnt = 0;
  bit       exp_rf, exp_wf, exp_en, exp_busy;
  logic [2:0] exp_cmd;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit urg_now();
`ifdef DDR3_ARB_RD_URGENT_EN
    return rd_urgent;
`else
    return 1'b0;
`endif
  endfunction

  task automatic eval_cycle();
    cmd_t e;
    exp_rf   = (g == 2) && rd_app_en && ddr3_app_rdy;
    exp_wf   = (g == 3) && wr_app_en && ddr3_app_rdy && ddr3_app_wdf_rdy;
    exp_en   = (g == 2) ? rd_app_en : ((g == 3) ? (wr_app_en && ddr3_app_wdf_rdy) : 1'b0);
    exp_cmd  = (g == 3) ? 3'b000 : 3'b001;
    exp_busy = (g >= 2);
    if (exp_rf) begin
      e.cmd = 3'b001; e.addr = rd_app_addr; e.data = '0; e.mask = '0;
      sb.push_back(e);
    end
    if (exp_wf) begin
      e.cmd = 3'b000; e.addr = wr_app_addr; e.data = wr_app_data; e.mask = wr_app_mask;
      sb.push_back(e);
    end
  endtask

  task automatic advance();
    int ng;
    int nc;
    ng = g;
    nc = cnt;
    if (!calib_done) begin
      ng = 0;
      nc = 0;
    end else if (g == 0) begin
      ng = 1;
    end else if (g == 1) begin
      ng = rd_app_en ? 2 : (wr_app_en ? 3 : 1);
    end else if (g == 2) begin
      if (!rd_app_en && !urg_now()) ng = wr_app_en ? 3 : 1;
    end else begin
      nc = (exp_wf && cnt < Q) ? cnt + 1 : cnt;
      if (!wr_app_en) ng = rd_app_en ? 2 : 1;
      else if (rd_app_en && (nc == Q || urg_now())) ng = 2;
    end
    if (ng == 3 && g != 3) nc = 0;
    g   = ng;
    cnt = nc;
  endtask

  always @(negedge clk) begin
    cmd_t e;
    if (reset_chk) begin
      chk("rst_app_en", DW'(ddr3_app_en), DW'(1'b0));
      chk("rst_wren",   DW'(ddr3_app_wdf_wren), DW'(1'b0));
      chk("rst_end",    DW'(ddr3_app_wdf_end), DW'(1'b0));
      chk("rst_rd_rdy", DW'(rd_app_rdy), DW'(1'b0));
      chk("rst_wr_rdy", DW'(wr_app_rdy), DW'(1'b0));
      chk("rst_busy",   DW'(arb_busy), DW'(1'b0));
      chk("rst_cmd",    DW'(ddr3_app_cmd), DW'(3'b001));
    end
    if (running) begin
      chk("app_en", DW'(ddr3_app_en), DW'(exp_en));
      chk("cmd",    DW'(ddr3_app_cmd), DW'(exp_cmd));
      chk("busy",   DW'(arb_busy), DW'(exp_busy));
      chk("rd_rdy", DW'(rd_app_rdy), DW'(exp_rf));
      chk("wr_rdy", DW'(wr_app_rdy), DW'(exp_wf));
      chk("wren",   DW'(ddr3_app_wdf_wren), DW'(exp_wf));
      chk("wdf_end", DW'(ddr3_app_wdf_end), DW'(exp_wf));
      if (ddr3_app_en && ddr3_app_rdy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_cmd: got cmd %0h addr %0h required none", ddr3_app_cmd, ddr3_app_addr);
        end else begin
          e = sb.pop_front();
          chk("sb_cmd",  DW'(ddr3_app_cmd), DW'(e.cmd));
          chk("sb_addr", DW'(ddr3_app_addr), DW'(e.addr));
          if (e.cmd == 3'b000) begin
            chk("sb_data", ddr3_app_wdf_data, e.data);
            chk("sb_mask", DW'(ddr3_app_wdf_mask), DW'(e.mask));
          end
        end
      end
      if (sb.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_cmd: got no command required cmd %0h addr %0h", sb[0].cmd, sb[0].addr);
        sb.delete();
      end
    end
  end

  initial begin
    bit rd_acc, wr_acc;
    int calib_low;
    int rd_pct;
    logic [AW-1:0] rd_next;
    rd_app_en = 1'b1;
    rd_app_addr = '0;
    rd_next = '0;
    wr_app_en = 1'b1;
    wr_app_addr = AW'($urandom);
    wr_app_data = {$urandom, $urandom, $urandom, $urandom};
    wr_app_mask = MW'($urandom);
    repeat (2) @(posedge clk);
    #1 reset_chk = 1'b1;
    @(posedge clk);
    #1 reset_chk = 1'b0;
    rst = 1'b0;
    g = 0;
    cnt = 0;
    calib_low = 5;
    running = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      eval_cycle();
      @(negedge clk);
      rd_acc = rd_app_rdy;
      wr_acc = wr_app_rdy;
      @(posedge clk);
      #1;
      advance();
      rd_pct = ((c / 250) % 3 == 0) ? 10 : (((c / 250) % 3 == 1) ? 50 : 90);
      if (rd_acc) begin
        rd_next = rd_next + AW'(8);
        rd_app_en = 1'b0;
      end
      if (!rd_app_en && ($urandom_range(99) < rd_pct)) begin
        rd_app_en = 1'b1;
        rd_app_addr = rd_next;
      end
      if (wr_acc) wr_app_en = 1'b0;
      if (!wr_app_en && ($urandom_range(99) < 85)) begin
        wr_app_en = 1'b1;
        wr_app_addr = AW'($urandom);
        wr_app_data = {$urandom, $urandom, $urandom, $urandom};
        wr_app_mask = MW'($urandom);
      end
      ddr3_app_rdy = ($urandom_range(3) != 0);
      ddr3_app_wdf_rdy = ($urandom_range(4) != 0);
      if (calib_low > 0) calib_low--;
      else if ($urandom_range(299) == 0) calib_low = 3;
      calib_done = (calib_low == 0);
`ifdef DDR3_ARB_RD_URGENT_EN
      rd_urgent = ($urandom_range(7) == 0);
`endif
    end
    running = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
